h264_core_transform: RTL



---
 rtl/h264_tx_pkg.sv | 38 +++
 rtl/h264_tx_butterfly.sv | 32 +++
 rtl/h264_core_transform.sv | 135 +++++++++++++
 3 files changed

// File: rtl/h264_tx_pkg.sv
// Shared widths, storage types, zig-zag scan and column-pass helper for the
// 4x4 forward core transform.
package h264_tx_pkg;

  localparam int IN_W  = 9;
  localparam int ROW_W = 12;
  localparam int OUT_W = 16;

  typedef logic signed [ROW_W-1:0] rv_t;
  typedef rv_t  [3:0] row_t;
  typedef row_t [3:0] blk_t;

  typedef enum logic {S_IDLE, S_STREAM} ostate_e;

  // ZZ[p] = raster index of scan position p (listed from p=15 down to p=0)
  localparam logic [15:0][3:0] ZZ = {
    4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
    4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0
  };

  // Output i of the column butterfly over column values r0..r3.
  function automatic logic [OUT_W-1:0] col_coef(input rv_t r0, input rv_t r1,
                                                input rv_t r2, input rv_t r3,
                                                input logic [1:0] i);
    logic signed [OUT_W-1:0] a, b, c, d;
    a = OUT_W'(r0);
    b = OUT_W'(r1);
    c = OUT_W'(r2);
    d = OUT_W'(r3);
    case (i)
      2'd0:    return a + b + c + d;
      2'd1:    return (a <<< 1) + b - c - (d <<< 1);
      2'd2:    return a - b - c + d;
      default: return a - (b <<< 1) + (c <<< 1) - d;
    endcase
  endfunction

endpackage

// File: rtl/h264_tx_butterfly.sv
// Combinational 4-point forward butterfly; mode_i=0 emits all four outputs,
// mode_i=1 emits only output sel_i in lane 0.
module h264_tx_butterfly #(
  parameter int W_I = 9,
  parameter int W_O = 12
) (
  input  logic [3:0][W_I-1:0] a_i,
  input  logic                mode_i,
  input  logic [1:0]          sel_i,
  output logic [3:0][W_O-1:0] y_o
);

  logic signed [W_O-1:0] x [4];
  logic signed [W_O-1:0] r [4];
  logic signed [W_O-1:0] s03, d03, s12, d12;

  always_comb begin
    for (int k = 0; k < 4; k++) x[k] = W_O'($signed(a_i[k]));
    s03  = x[0] + x[3];
    d03  = x[0] - x[3];
    s12  = x[1] + x[2];
    d12  = x[1] - x[2];
    r[0] = s03 + s12;
    r[1] = (d03 <<< 1) + d12;
    r[2] = s03 - s12;
    r[3] = d03 - (d12 <<< 1);
    y_o  = '0;
    if (mode_i) y_o[0] = r[sel_i];
    else for (int k = 0; k < 4; k++) y_o[k] = r[k];
  end

endmodule

// File: rtl/h264_core_transform.sv
// 4x4 forward core transform: row pass on capture into a double-banked block
// store, column pass on readout, coefficients streamed in zig-zag order.
module h264_core_transform
  import h264_tx_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              STROBEI,
  input  logic [4*IN_W-1:0] DATAI,
  output logic              READYO,
  output logic              VALIDO,
  input  logic              OREADY,
  output logic [OUT_W-1:0]  COEFO,
  output logic [3:0]        IDXO,
  output logic              LASTO
);

  row_t             row_new;
  blk_t             bank_q [2];
  logic [1:0]       full_q, full_d;
  logic             wr_q, wr_d, rd_q, rd_d;
  logic [1:0]       rowcnt_q, rowcnt_d;
  ostate_e          state_q, state_d;
  logic [OUT_W-1:0] coef_q, coef_d;
  logic [3:0]       idx_q, idx_d;
  logic             last_q, last_d;
  logic             cap, rel, load, nb;
  logic [3:0]       np, z;

  h264_tx_butterfly #(.W_I(IN_W), .W_O(ROW_W)) u_row (
    .a_i    (DATAI),
    .mode_i (1'b0),
    .sel_i  (2'd0),
    .y_o    (row_new)
  );

  assign READYO = !full_q[wr_q];
  assign VALIDO = (state_q == S_STREAM);
  assign COEFO  = coef_q;
  assign IDXO   = idx_q;
  assign LASTO  = last_q;

  always_comb begin
    cap      = STROBEI && READYO;
    full_d   = full_q;
    wr_d     = wr_q;
    rowcnt_d = rowcnt_q;
    state_d  = state_q;
    rd_d     = rd_q;
    coef_d   = coef_q;
    idx_d    = idx_q;
    last_d   = last_q;
    rel      = 1'b0;
    load     = 1'b0;
    nb       = rd_q;
    np       = '0;

    if (cap) begin
      rowcnt_d = rowcnt_q + 2'd1;
      if (rowcnt_q == 2'd3) begin
        full_d[wr_q] = 1'b1;
        wr_d         = ~wr_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_q]) begin
          load    = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (OREADY) begin
          if (idx_q == 4'd15) begin
            rel  = 1'b1;
            rd_d = ~rd_q;
            // Other bank already complete: start it on the next cycle, no bubble
            if (full_q[~rd_q]) begin
              load = 1'b1;
              nb   = ~rd_q;
            end else begin
              state_d = S_IDLE;
              coef_d  = '0;
              idx_d   = '0;
              last_d  = 1'b0;
            end
          end else begin
            load = 1'b1;
            np   = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rel) full_d[rd_q] = 1'b0;

    z = ZZ[np];
    if (load) begin
      coef_d = col_coef(bank_q[nb][0][z[1:0]], bank_q[nb][1][z[1:0]],
                        bank_q[nb][2][z[1:0]], bank_q[nb][3][z[1:0]], z[3:2]);
      idx_d  = np;
      last_d = (np == 4'd15);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      rowcnt_q <= '0;
      state_q  <= S_IDLE;
      coef_q   <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      rowcnt_q <= rowcnt_d;
      state_q  <= state_d;
      coef_q   <= coef_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  // Bank contents are only meaningful once full, so they need no reset.
  always_ff @(posedge CLK) begin
    if (cap) bank_q[wr_q][rowcnt_q] <= row_new;
  end

endmodule
